// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, debounces
// the synchronized rows and reports one key code per physical press.
module keypad_scanner #(
  parameter int COL_HOLD        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       scan_clk,
  input  logic       rst_n,
  input  logic       row_1,
  input  logic       row_2,
  input  logic       row_3,
  input  logic       row_4,
  output logic       col_1,
  output logic       col_2,
  output logic       col_3,
  output logic       col_4,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int HW = $clog2(COL_HOLD);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(COL_HOLD - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FIRST = CW'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [CW-1:0]   cnt;
  logic [1:0]      col_idx;
  logic [1:0]      cand;
  logic [3:0]      col_n;
  logic [3:0]      sync_1;
  logic [3:0]      rs;
  logic [1:0]      col_idx_nxt;
  logic [3:0]      col_n_nxt;

  // Lowest-numbered low row wins when several keys share the driven column.
  function automatic logic [1:0] lowest_low(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // NOTE: an asynchronous reset must appear in the sensitivity list; every
  // flop here is reset so outputs are defined the moment rst_n falls.
  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 4'hF;
      rs     <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments make both stages shift on the same
      // edge; blocking here would collapse the synchronizer to one flop.
      sync_1 <= {row_4, row_3, row_2, row_1};
      rs     <= sync_1;
    end
  end

  assign col_idx_nxt = col_idx + 2'd1;
  assign col_n_nxt   = ~(4'b0001 << col_idx_nxt);

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      hold_cnt  <= '0;
      cnt       <= '0;
      col_idx   <= 2'd0;
      col_n     <= 4'b1110;
      cand      <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (hold_cnt == HOLD_LAST) begin
            if (rs == 4'hF) begin
              col_idx  <= col_idx_nxt;
              col_n    <= col_n_nxt;
              hold_cnt <= '0;
            end else begin
              cand  <= lowest_low(rs);
              cnt   <= CNT_FIRST;
              state <= DEBOUNCE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (rs[cand]) begin
            state    <= SCAN;
            col_idx  <= col_idx_nxt;
            col_n    <= col_n_nxt;
            hold_cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            key_code  <= {cand, col_idx};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Column stays parked on the pressed key; only its own row matters.
        HELD: begin
          if (rs[cand]) begin
            cnt   <= CNT_FIRST;
            state <= RELEASE;
          end
        end

        RELEASE: begin
          if (!rs[cand]) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            key_held <= 1'b0;
            state    <= SCAN;
            col_idx  <= col_idx_nxt;
            col_n    <= col_n_nxt;
            hold_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign col_1 = col_n[0];
  assign col_2 = col_n[1];
  assign col_3 = col_n[2];
  assign col_4 = col_n[3];

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans and decodes the 4x4 matrix keypad used for countdown setup. Drives the column lines itself and samples the active-low row lines through a synchronizer. It debounces press and release, then reports one 4-bit key code per physical press to the countdown control logic. Holds on a pressed key's column until release, so each press yields exactly one `key_valid` pulse.

## Interface
Parameters:
- `COL_HOLD`, default 4: scan_clk cycles each column is driven before its rows are sampled; legal range ≥3.
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples needed to accept a press or release; legal range ≥2.

Ports:
- `scan_clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `row_1`..`row_4` input 1 each: keypad rows, pulled high; low means a key on the driven column is closed. Asynchronous to `scan_clk`.
- `col_1`..`col_4` output 1 each: one-hot active-low column drive; exactly one is low at all times.
- `key_code` output 4: last accepted key, = row_idx*4 + col_idx, where `row_1`/`col_1` is index 0.
- `key_valid` output 1: one-cycle pulse when `key_code` is updated.
- `key_held` output 1: high from press acceptance until release acceptance.

## Operation
- Rows pass through a 2-flop synchronizer. Flops reset to 1. `rs[3:0]` is the synchronized value.
- `hold_cnt` counts 0..COL_HOLD-1 in SCAN. `col_idx` is 2 bits, wraps 3→0. `cnt` is the debounce counter. `cand` holds the candidate row index.
- SCAN:
  - Each cycle `hold_cnt`++.
  - At `hold_cnt`==COL_HOLD-1 this is the sample edge. If `rs`==4'hF: `col_idx`++ and `hold_cnt`<=0.
  - Otherwise: `cand` <= lowest index with `rs` low, `cnt`<=1, go DEBOUNCE. The column is not advanced.
- DEBOUNCE (column held):
  - If `rs[cand]`==1: go SCAN, advance column, `hold_cnt`<=0.
  - Else if `cnt`==DEBOUNCE_CYCLES-1: `key_code`<=cand*4+col_idx, `key_valid`<=1, `key_held`<=1, go HELD.
  - Else `cnt`++.
- HELD (column held): if `rs[cand]`==1, `cnt`<=1 and go RELEASE. Otherwise stay.
- RELEASE (column held):
  - If `rs[cand]`==0: go HELD. No new `key_valid`, `key_code` unchanged.
  - Else if `cnt`==DEBOUNCE_CYCLES-1: `key_held`<=0, go SCAN, advance column, `hold_cnt`<=0.
  - Else `cnt`++.
- Only `rs[cand]` is watched outside SCAN. Other keys pressed meanwhile are ignored until release completes.
- Multiple rows low at a sample edge: the lowest row index wins.
- `key_valid` defaults to 0 every cycle it is not set.

## Timing
- Reset values:
  - State SCAN, `col_idx`=0 (`col_1`=0, others 1), `hold_cnt`=0, `cnt`=0, `cand`=0.
  - `key_code`=0, `key_valid`=0, `key_held`=0, synchronizer = 4'hF.
- Reset asserted in any state returns immediately (asynchronously) to the above. Outputs drop in the same cycle.
- Columns are registered outputs. A row change reaches `rs` 2 edges later. COL_HOLD≥3 guarantees each sample reflects the current column.
- Column period in SCAN with no key: COL_HOLD cycles. Full sweep: 4*COL_HOLD.
- Press acceptance takes DEBOUNCE_CYCLES consecutive low samples, counting the SCAN sample edge. `key_valid` is high in the cycle after the final sample. `key_held` rises in the same cycle.
- Release takes DEBOUNCE_CYCLES consecutive high samples. `key_held` falls the cycle after the last one. SCAN resumes at the next column with `hold_cnt`=0.

## Test plan
- Reset defaults: rows all high, release `rst_n` → `col_1` low for 4 cycles, then `col_2`, `col_3`, `col_4`, `col_1`; `key_valid`=0, `key_code`=0.
- Clean press, COL_HOLD=4, DEBOUNCE_CYCLES=4: hold `row_2` low whenever `col_3` is low → exactly one `key_valid` with `key_code`=6. `key_held`=1 and `col_3` stays low while pressed. After release plus 4 high samples, `key_held`=0 and `col_4` goes low next.
- Press bounce: `row_2` low for only 2 samples during `col_3` → no `key_valid`, `key_held` stays 0, scan moves on to `col_4`.
- Release bounce: with key 6 held, raise `row_2` for 2 cycles then lower it → `key_held` stays 1, no second `key_valid`. A later clean release clears `key_held`.
- Two keys: `row_1` and `row_3` both low at `col_2` → `key_code`=1. Lowering `row_4` while held produces no new pulse.
- Reset mid-HELD: assert `rst_n`=0 while `key_held`=1 → `key_held`, `key_code`, `key_valid` go to 0 at once and `col_1` goes low. After reset, a key still pressed is re-detected and produces one `key_valid`.
